// File: rtl/ddr3_rd_checker.sv
// ddr3_rd_checker: snoops accepted DDR3 read commands, queues {addr, tag},
// pops one entry per returned beat and checks the data against the tagged
// 64-bit pattern. Optional first-failure data capture: DDR3_CHK_CAPTURE_EN.
module ddr3_rd_checker #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int FIFO_AW        = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int DRAIN_TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_calib_complete,
    input  logic                        app_en,
    input  logic [2:0]                  app_cmd,
    input  logic                        app_rdy,
    input  logic [ADDR_WIDTH-1:0]       app_addr,
    input  logic [2:0]                  cmd_tag,
    input  logic                        app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        test_end,
    input  logic                        clear,
    output logic [APP_DATA_WIDTH/16-1:0] err_lane,
    output logic [CNT_WIDTH-1:0]        err_cnt,
    output logic [CNT_WIDTH-1:0]        rd_cnt,
    output logic [ADDR_WIDTH-1:0]       first_err_addr,
    output logic                        first_err_valid,
    output logic                        orphan,
    output logic                        tag_ovf,
    output logic [APP_DATA_WIDTH-1:0]   first_err_rdata,
    output logic [APP_DATA_WIDTH-1:0]   first_err_exp,
    output logic                        done,
    output logic                        pass
);
    localparam int LANES = APP_DATA_WIDTH / 16;
    localparam int REP   = APP_DATA_WIDTH / 64;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = ADDR_WIDTH + 3;
    localparam int DW    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [63:0] pattern(input logic [2:0] t);
        case (t)
            3'd0:    pattern = 64'h5883adb4c88ad596;
            3'd1:    pattern = 64'h1122334455667788;
            3'd2:    pattern = 64'h99aabbccddeeff00;
            3'd3:    pattern = 64'h0000ffff0000ffff;
            3'd4:    pattern = 64'hffff0000ffff0000;
            3'd5:    pattern = 64'h00000000ffff0000;
            3'd6:    pattern = 64'haf5d632fc8b91658;
            default: pattern = 64'hffffffff0000ffff;
        endcase
    endfunction

    logic [1:0]          state;
    logic [DW-1:0]       drain_cnt;
    logic                timeout;
    logic [EW-1:0]       mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                s1_vld, s1_orphan;
    logic [APP_DATA_WIDTH-1:0] s1_data;
    logic [EW-1:0]       s1_entry;

    logic beat, push_req, push, pop, fifo_empty, fifo_full, ovf, mism, drain_idle;
    logic [APP_DATA_WIDTH-1:0] exp_beat;
    logic [LANES-1:0]    lane_diff;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
    assign beat       = app_rd_data_valid && (state == S_RUN || state == S_DRAIN);
    assign push_req   = app_en && app_rdy && (app_cmd == 3'b001) && (state == S_RUN);
    // Pop looks at the pre-edge count, so a same-edge push is never popped.
    assign pop        = beat && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign ovf        = push_req && fifo_full && !pop;
    assign drain_idle = fifo_empty && !s1_vld && !beat;

    // Stage-2 compare: per-lane difference against the replicated pattern.
    always_comb begin
        exp_beat  = {REP{pattern(s1_entry[2:0])}};
        lane_diff = '0;
        for (int i = 0; i < LANES; i++)
            lane_diff[i] = (s1_data[16*i +: 16] != exp_beat[16*i +: 16]);
        mism = s1_vld && !s1_orphan && (lane_diff != '0);
    end

    // FIFO storage and stage-1 data capture; contents are qualified by valid flags.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {app_addr, cmd_tag};
        s1_data  <= app_rd_data;
        s1_entry <= mem[rd_ptr];
    end

    // FSM, FIFO pointers, stage-1 valid and all checker results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            state <= S_IDLE; drain_cnt <= '0; timeout <= 1'b0;
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            s1_vld <= 1'b0; s1_orphan <= 1'b0;
            err_lane <= '0; err_cnt <= '0; rd_cnt <= '0;
            first_err_addr <= '0; first_err_valid <= 1'b0;
            orphan <= 1'b0; tag_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf) tag_ovf <= 1'b1;

            s1_vld    <= beat;
            s1_orphan <= beat && fifo_empty;

            if (s1_vld) begin
                if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
                if (s1_orphan) orphan <= 1'b1;
                if ((s1_orphan || mism) && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
            end
            if (mism) begin
                err_lane <= err_lane | lane_diff;
                if (!first_err_valid) begin
                    first_err_addr  <= s1_entry[EW-1:3];
                    first_err_valid <= 1'b1;
                end
            end

            case (state)
                S_IDLE:  if (init_calib_complete) state <= S_RUN;
                S_RUN:   if (test_end) begin state <= S_DRAIN; drain_cnt <= '0; end
                S_DRAIN: begin
                    if (drain_idle) state <= S_DONE;
                    else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
                        state <= S_DONE; timeout <= 1'b1;
                    end else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= S_DONE;
            endcase
        end
    end

`ifdef DDR3_CHK_CAPTURE_EN
    logic [APP_DATA_WIDTH-1:0] cap_rdata, cap_exp;
    // First-mismatch data capture, frozen once first_err_valid is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            cap_rdata <= '0; cap_exp <= '0;
        end else if (mism && !first_err_valid) begin
            cap_rdata <= s1_data; cap_exp <= exp_beat;
        end
    end
    assign first_err_rdata = cap_rdata;
    assign first_err_exp   = cap_exp;
`else
    assign first_err_rdata = '0;
    assign first_err_exp   = '0;
`endif

    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0) && !orphan && !tag_ovf && !timeout && (rd_cnt != '0);
endmodule

// File: tb/tb_ddr3_rd_checker.sv
// Self-checking bench for ddr3_rd_checker: directed scenarios plus a random
// run, checked every cycle against a queue-based behavioural model.
module tb_ddr3_rd_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_calib_complete = 1'b0, app_en = 1'b0, app_rdy = 1'b0;
    logic [2:0] app_cmd = 3'd0, cmd_tag = 3'd0;
    logic [27:0] app_addr = '0;
    logic app_rd_data_valid = 1'b0, test_end = 1'b0, clear = 1'b0;
    logic [127:0] app_rd_data = '0;
    logic [7:0] err_lane;
    logic [15:0] err_cnt, rd_cnt;
    logic [27:0] first_err_addr;
    logic first_err_valid, orphan, tag_ovf, done, pass;
    logic [127:0] first_err_rdata, first_err_exp;

    ddr3_rd_checker dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .app_en(app_en), .app_cmd(app_cmd), .app_rdy(app_rdy), .app_addr(app_addr),
        .cmd_tag(cmd_tag), .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .test_end(test_end), .clear(clear), .err_lane(err_lane), .err_cnt(err_cnt),
        .rd_cnt(rd_cnt), .first_err_addr(first_err_addr), .first_err_valid(first_err_valid),
        .orphan(orphan), .tag_ovf(tag_ovf), .first_err_rdata(first_err_rdata),
        .first_err_exp(first_err_exp), .done(done), .pass(pass));

    always #5 clk = ~clk;

    logic [63:0] P [8] = '{64'h5883adb4c88ad596, 64'h1122334455667788, 64'h99aabbccddeeff00,
                           64'h0000ffff0000ffff, 64'hffff0000ffff0000, 64'h00000000ffff0000,
                           64'haf5d632fc8b91658, 64'hffffffff0000ffff};

    int checks = 0, failures = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [27:0] addr; logic [2:0] tag; } ent_t;
    ent_t q[$];
    int ph;                 // 0 idle, 1 run, 2 drain, 3 done
    int dcyc;
    bit m_tmo, m_orph, m_ovf, m_fv;
    int m_err, m_rd;
    logic [7:0] m_lane;
    logic [27:0] m_faddr;
    logic [127:0] m_frd, m_fexp;
    bit pv, porph; logic [127:0] pdata; ent_t pent;

    function automatic void model_reset();
        q.delete(); ph = 0; dcyc = 0; m_tmo = 0; m_orph = 0; m_ovf = 0; m_fv = 0;
        m_err = 0; m_rd = 0; m_lane = 0; m_faddr = 0; m_frd = 0; m_fexp = 0; pv = 0; porph = 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) model_reset();
        else begin
            bit had_pend, q_was_empty, bt, cm;
            had_pend = pv; q_was_empty = (q.size() == 0);
            // effect of the beat taken one edge earlier
            if (pv) begin
                if (m_rd < 65535) m_rd++;
                if (porph) begin
                    m_orph = 1; if (m_err < 65535) m_err++;
                end else begin
                    logic [127:0] eb; logic [7:0] d;
                    eb = {2{P[pent.tag]}}; d = 0;
                    for (int i = 0; i < 8; i++) d[i] = (pdata[16*i +: 16] != eb[16*i +: 16]);
                    if (d != 0) begin
                        if (m_err < 65535) m_err++;
                        m_lane |= d;
                        if (!m_fv) begin m_fv = 1; m_faddr = pent.addr; m_frd = pdata; m_fexp = eb; end
                    end
                end
            end
            pv = 0;
            bt = app_rd_data_valid && (ph == 1 || ph == 2);
            cm = app_en && app_rdy && app_cmd == 3'b001 && ph == 1;
            if (bt) begin
                pv = 1; pdata = app_rd_data; porph = q_was_empty;
                if (!q_was_empty) pent = q.pop_front();
            end
            if (cm) begin
                if (q.size() < 16) q.push_back('{app_addr, cmd_tag});
                else m_ovf = 1;
            end
            case (ph)
                0: if (init_calib_complete) ph = 1;
                1: if (test_end) begin ph = 2; dcyc = 0; end
                2: begin
                    dcyc++;
                    if (q_was_empty && !had_pend && !bt) ph = 3;
                    else if (dcyc == 1024) begin ph = 3; m_tmo = 1; end
                end
                default: ;
            endcase
        end
    end

    // per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            bit md;
            md = (ph == 3);
            cmp("err_lane", err_lane, m_lane);
            cmp("err_cnt", err_cnt, m_err);
            cmp("rd_cnt", rd_cnt, m_rd);
            cmp("first_err_valid", first_err_valid, m_fv);
            cmp("first_err_addr", first_err_addr, m_faddr);
            cmp("orphan", orphan, m_orph);
            cmp("tag_ovf", tag_ovf, m_ovf);
            cmp("done", done, md);
            cmp("pass", pass, md && m_err == 0 && !m_orph && !m_ovf && !m_tmo && m_rd != 0);
`ifdef DDR3_CHK_CAPTURE_EN
            cmp("first_err_rdata", first_err_rdata, m_frd);
            cmp("first_err_exp", first_err_exp, m_fexp);
`else
            cmp("first_err_rdata", first_err_rdata, 128'd0);
            cmp("first_err_exp", first_err_exp, 128'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic quiet();
        app_en = 0; app_rdy = 0; app_cmd = 0; app_rd_data_valid = 0; test_end = 0; clear = 0;
    endtask
    task automatic idle(input int n);
        quiet(); repeat (n) @(negedge clk);
    endtask
    task automatic set_rd(input logic [27:0] a, input logic [2:0] t);
        app_en = 1; app_rdy = 1; app_cmd = 3'b001; app_addr = a; cmd_tag = t;
    endtask
    task automatic rd(input logic [27:0] a, input logic [2:0] t);
        quiet(); set_rd(a, t); @(negedge clk);
    endtask
    task automatic bt(input logic [127:0] d);
        quiet(); app_rd_data_valid = 1; app_rd_data = d; @(negedge clk);
    endtask
    task automatic fin();
        quiet(); test_end = 1; @(negedge clk); quiet();
    endtask
    task automatic do_clear();
        quiet(); clear = 1; @(negedge clk); idle(2);
    endtask
    task automatic wait_done(input int budget);
        int n; n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        cmp("wait_done", done, 1'b1);
    endtask
    task automatic run_clean();
        for (int i = 0; i < 8; i++) rd(i, i[2:0]);
        for (int i = 0; i < 8; i++) bt({2{P[i]}});
        idle(2); fin(); wait_done(50);
    endtask

    initial begin
        logic [2:0] sq[$];
        quiet();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        cmp("reset_rd_cnt", rd_cnt, 0);
        cmp("reset_done", done, 0);
        init_calib_complete = 1;
        idle(2);

        // clean run: 8 reads, correct data
        run_clean();
        cmp("s1_rd_cnt", rd_cnt, 8);
        cmp("s1_err_cnt", err_cnt, 0);
        cmp("s1_pass", pass, 1);

        // beat 3 with bit 20 flipped
        do_clear();
        for (int i = 0; i < 8; i++) rd(i, i[2:0]);
        for (int i = 0; i < 8; i++) bt(i == 3 ? ({2{P[i]}} ^ (128'd1 << 20)) : {2{P[i]}});
        idle(2); fin(); wait_done(50);
        cmp("s2_err_lane", err_lane, 8'h02);
        cmp("s2_err_cnt", err_cnt, 1);
        cmp("s2_first_addr", first_err_addr, 3);
        cmp("s2_pass", pass, 0);
`ifdef DDR3_CHK_CAPTURE_EN
        cmp("s2_first_exp", first_err_exp, {2{64'h0000ffff0000ffff}});
`endif

        // orphan beat
        do_clear();
        bt({2{P[0]}});
        idle(2);
        cmp("s3_orphan", orphan, 1);
        cmp("s3_err_cnt", err_cnt, 1);
        fin(); wait_done(50);
        cmp("s3_pass", pass, 0);

        // 17 reads, no returns: overflow, drain timeout
        do_clear();
        for (int i = 0; i < 17; i++) rd(i, 3'd1);
        idle(1);
        cmp("s4_tag_ovf", tag_ovf, 1);
        fin();
        idle(1000);
        cmp("s4_not_done_early", done, 0);
        wait_done(60);
        cmp("s4_pass", pass, 0);

        // reset mid-drain, then a clean run
        do_clear();
        for (int i = 0; i < 5; i++) rd(i, 3'd2);
        fin(); idle(3);
        #2 rst = 1; #1;
        cmp("s5_rst_done", done, 0);
        cmp("s5_rst_err_cnt", err_cnt, 0);
        @(negedge clk); rst = 0; @(negedge clk);
        cmp("s5_rst_rd_cnt", rd_cnt, 0);
        cmp("s5_rst_tag_ovf", tag_ovf, 0);
        idle(2);
        run_clean();
        cmp("s5_pass", pass, 1);

        // read and orphan beat on the same edge, then a correct beat
        do_clear();
        quiet(); set_rd(28'd9, 3'd5); app_rd_data_valid = 1; app_rd_data = '0; @(negedge clk);
        bt({2{P[5]}});
        idle(3);
        cmp("s6_orphan", orphan, 1);
        cmp("s6_err_cnt", err_cnt, 1);
        cmp("s6_rd_cnt", rd_cnt, 2);
        cmp("s6_err_lane", err_lane, 0);

        // randomized traffic
        do_clear();
        for (int c = 0; c < 400; c++) begin
            quiet();
            if (sq.size() > 0 && $urandom_range(0, 2) == 0) begin
                logic [2:0] t; logic [127:0] d;
                t = sq.pop_front(); d = {2{P[t]}};
                if ($urandom_range(0, 19) == 0) d[$urandom_range(0, 127)] ^= 1'b1;
                app_rd_data_valid = 1; app_rd_data = d;
            end
            if (sq.size() < 12 && $urandom_range(0, 2) == 0) begin
                logic [2:0] t;
                t = 3'($urandom_range(0, 7));
                app_en = 1; app_addr = 28'($urandom); cmd_tag = t;
                app_rdy = ($urandom_range(0, 4) != 0);
                app_cmd = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'b001;
                if (app_rdy && app_cmd == 3'b001) sq.push_back(t);
            end
            @(negedge clk);
        end
        fin();
        while (sq.size() > 0) begin
            if ($urandom_range(0, 1) == 0) bt({2{P[sq.pop_front()]}});
            else idle(1);
        end
        wait_done(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
